wb_trace_buffer: RTL

- Synthesizable writeback-trace capture block for the pipelined RISC-V processor; replaces per-cycle $monitor dumps of register writes with a hardware circular buffer.
- Each committed register write is recorded as {timestamp, pc, rd, data}: WB-stage pc, destination register, and the value from the WB mem/ALU mux.
- The bench, or a later debug port, drains entries through a pop/valid read interface.
- Parametrised in depth and widths; adds rd filtering, wrap/stop modes and a sticky overflow flag.

---
 rtl/wb_trace_buffer_pkg.sv | 35 +++
 rtl/wb_trace_buffer_if.sv | 42 ++++
 rtl/wb_trace_buffer_ram.sv | 34 +++
 rtl/wb_trace_buffer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the writeback trace buffer: default widths and
// the per-cycle capture decision.
package wb_trace_buffer_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;
  localparam int TS_W_DEF   = 16;
  localparam int DEPTH_DEF  = 16;

  // Packed entry layout, LSB first: data | rd | pc | ts
  function automatic int entry_w(input int ts_w, input int data_w, input int rd_w);
    return ts_w + data_w + rd_w + data_w;
  endfunction

  function automatic int off_rd(input int data_w);
    return data_w;
  endfunction

  function automatic int off_pc(input int data_w, input int rd_w);
    return data_w + rd_w;
  endfunction

  function automatic int off_ts(input int data_w, input int rd_w);
    return data_w + rd_w + data_w;
  endfunction

  // What a qualified capture does this cycle
  typedef enum logic [1:0] {
    CAP_NONE      = 2'd0,
    CAP_WRITE     = 2'd1,  // free slot (or one freed by a same-cycle pop)
    CAP_OVERWRITE = 2'd2,  // full, wrap mode: discard oldest
    CAP_DROP      = 2'd3   // full, stop mode: entry lost
  } cap_action_e;

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Capture/readout bus of the trace buffer. master = debug side, slave = buffer.
interface wb_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clear;
  logic              cap_en;
  logic              stop_mode;
  logic              filter_en;
  logic [RD_W-1:0]   filter_rd;
  logic              wb_we;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] wb_pc;
  logic              pop;
  logic              rd_valid;
  logic [TS_W-1:0]   rd_ts;
  logic [DATA_W-1:0] rd_pc;
  logic [RD_W-1:0]   rd_rd;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;

  modport master (
    output clear, cap_en, stop_mode, filter_en, filter_rd,
           wb_we, wb_rd, wb_data, wb_pc, pop,
    input  rd_valid, rd_ts, rd_pc, rd_rd, rd_data, count, empty, full, overflow
  );

  modport slave (
    input  clear, cap_en, stop_mode, filter_en, filter_rd,
           wb_we, wb_rd, wb_data, wb_pc, pop,
    output rd_valid, rd_ts, rd_pc, rd_rd, rd_data, count, empty, full, overflow
  );

endinterface

// File: rtl/wb_trace_buffer_ram.sv
// DEPTH x WIDTH entry storage: one synchronous write port, one registered
// read port. A read and write to the same slot returns the old contents.
module wb_trace_buffer_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 85,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage write; contents are not reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; holds the last popped entry between reads
  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Circular capture buffer of committed register writes {ts, pc, rd, data},
// drained one entry per pop with one cycle of read latency.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  wb_trace_buffer_if.slave  bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_w(TS_W, DATA_W, RD_W);
  localparam int RD_OFF  = off_rd(DATA_W);
  localparam int PC_OFF  = off_pc(DATA_W, RD_W);
  localparam int TS_OFF  = off_ts(DATA_W, RD_W);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TS_W-1:0]    ts_cnt_q;
  logic               overflow_q, overflow_d;
  logic               rd_valid_q;
  logic               cap, do_pop, full_w, empty_w, ram_we, ram_re;
  cap_action_e        cap_act;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);
  assign cap     = bus.cap_en & bus.wb_we & (bus.wb_rd != '0) &
                   (!bus.filter_en | (bus.wb_rd == bus.filter_rd));
  assign do_pop  = bus.pop & !empty_w;

  // Classify the capture; a same-cycle pop always frees a slot when full
  always_comb begin
    cap_act = CAP_NONE;
    if (cap) begin
      if (!full_w || do_pop) cap_act = CAP_WRITE;
      else if (bus.stop_mode) cap_act = CAP_DROP;
      else cap_act = CAP_OVERWRITE;
    end
  end

  // Next-state for pointers, count and sticky overflow; clear wins
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (cap_act == CAP_WRITE || cap_act == CAP_OVERWRITE)
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop || cap_act == CAP_OVERWRITE)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (cap_act == CAP_WRITE && !do_pop)
        count_d = count_q + CNT_W'(1);
      else if (cap_act != CAP_WRITE && do_pop)
        count_d = count_q - CNT_W'(1);
      if (cap_act == CAP_OVERWRITE || cap_act == CAP_DROP)
        overflow_d = 1'b1;
    end
  end

  assign ram_we   = !bus.clear & (cap_act == CAP_WRITE || cap_act == CAP_OVERWRITE);
  assign ram_re   = !bus.clear & do_pop;
  assign wr_entry = {ts_cnt_q, bus.wb_pc, bus.wb_rd, bus.wb_data};

  // State registers; the timestamp free-runs and ignores clear
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      ts_cnt_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= ram_re;
      ts_cnt_q   <= ts_cnt_q + TS_W'(1);
    end
  end

  wb_trace_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_entry[0 +: DATA_W];
  assign bus.rd_rd    = rd_entry[RD_OFF +: RD_W];
  assign bus.rd_pc    = rd_entry[PC_OFF +: DATA_W];
  assign bus.rd_ts    = rd_entry[TS_OFF +: TS_W];
  assign bus.count    = count_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.overflow = overflow_q;

endmodule
